// File: rtl/qspi_arb_pkg.sv
// Shared types for the QSPI port arbiter.
// Optional timeout is enabled with QSPI_ARB_TIMEOUT_EN.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/qspi_arb_rr.sv
// Two-way round-robin picker for the QSPI arbiter.
// Purely combinational; the caller owns last_grant.
module qspi_arb_rr
  import qspi_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = PORT_A;
    unique case (1'b1)
      (req_a && req_b):
        grant_id = (last_grant == PORT_A) ? PORT_B : PORT_A;
      (req_b && !req_a):
        grant_id = PORT_B;
      default:
        grant_id = PORT_A;
    endcase
  end

endmodule

// File: rtl/qspi_arbiter.sv
// Shares one qspi_if between fetch port A and data port B.
// Define QSPI_ARB_TIMEOUT_EN to enable the BUSY-state timeout.
module qspi_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [31:0] a_adr,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_rd_req,
  input  logic        b_wr_req,
  input  logic        b_w,
  input  logic        b_hw,
  input  logic [31:0] b_adr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        err,
  output logic        q_read_req,
  output logic        q_write_req,
  output logic        q_w,
  output logic        q_hw,
  output logic [31:0] q_adr,
  output logic [31:0] q_wdata,
  input  logic [31:0] q_read_data,
  input  logic        q_read_valid,
  input  logic        q_write_finish
);

  if (2 ** TO_W <= TIMEOUT_CYC) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYC");
  end

  state_t      r_state;
  state_t      w_next;
  logic        r_port;
  logic        r_op;
  logic        r_w;
  logic        r_hw;
  logic        r_last;
  logic        r_qrd;
  logic        r_qwr;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;
  logic        w_b_req;
  logic        w_gv;
  logic        w_gid;
  logic        w_grant;
  logic        w_fin;
  logic        w_cmpl;
  logic        w_to;
  logic [31:0] w_cap;
  logic        w_unused;

  assign w_unused = ^{a_adr[31:24], b_adr[31:24]};
  assign w_b_req  = b_rd_req | b_wr_req;
  assign w_cmpl   = (r_op == OP_RD) ? q_read_valid : q_write_finish;
  assign w_cap    = w_to ? TIMEOUT_DATA : q_read_data;

  qspi_arb_rr u_rr (
    .req_a       (a_req),
    .req_b       (w_b_req),
    .last_grant  (r_last),
    .grant_valid (w_gv),
    .grant_id    (w_gid)
  );

`ifdef QSPI_ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // A real completion in the final cycle wins over the timeout.
  assign w_to = (r_state == BUSY) && !w_cmpl &&
                (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_fin) begin
      r_err <= w_to;
    end
  end

  assign err = (r_state == DONE) && r_err;
`else
  assign w_to = 1'b0;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_fin   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gv) begin
          w_next  = ISSUE;
          w_grant = 1'b1;
        end
      end
      ISSUE: w_next = BUSY;
      BUSY: begin
        if (w_cmpl || w_to) begin
          w_next = DONE;
          w_fin  = 1'b1;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port    <= PORT_A;
      r_op      <= OP_RD;
      r_w       <= 1'b0;
      r_hw      <= 1'b0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_last    <= PORT_B;
      r_qrd     <= 1'b0;
      r_qwr     <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_qrd <= (r_state == ISSUE) && (r_op == OP_RD);
      r_qwr <= (r_state == ISSUE) && (r_op == OP_WR);
      if (w_grant) begin
        r_port <= w_gid;
        if (w_gid == PORT_A) begin
          r_op    <= OP_RD;
          r_w     <= 1'b1;
          r_hw    <= 1'b0;
          r_adr   <= {8'h00, a_adr[23:0]};
          r_wdata <= '0;
        end else begin
          r_op    <= b_rd_req ? OP_RD : OP_WR;
          r_w     <= b_w;
          r_hw    <= b_hw;
          r_adr   <= {8'h00, b_adr[23:0]};
          r_wdata <= b_wdata;
        end
      end
      if (w_fin && (r_op == OP_RD || w_to)) begin
        if (r_port == PORT_A) begin
          r_a_rdata <= w_cap;
        end else begin
          r_b_rdata <= w_cap;
        end
      end
      if (r_state == DONE) begin
        r_last <= r_port;
      end
    end
  end

  assign a_ack       = (r_state == DONE) && (r_port == PORT_A);
  assign b_ack       = (r_state == DONE) && (r_port == PORT_B);
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign q_read_req  = r_qrd;
  assign q_write_req = r_qwr;
  assign q_w         = r_w;
  assign q_hw        = r_hw;
  assign q_adr       = r_adr;
  assign q_wdata     = r_wdata;

endmodule
